dqn_update_sequencer: RTL
=========================

Name: dqn_update_sequencer

Overview:
- Sequences one training iteration of the DQN datapath: forward pass, backward pass, then the parameter-update commit.
- Drives the shared 4-bit ctrl/step command bus consumed by the weight and bias register blocks. Those blocks add their deltas only when ctrl = 4'b0001 and step != 0.
- Sits between the top-level training controller (start/done) and the per-layer parameter blocks.

Parameters:
- NUM_LAYERS, 2, number of parameter layers committed in sequence; legal range 1..4.
- WD_LIMIT, 255, watchdog cycle limit; used only when WATCHDOG_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one training iteration; sampled only in IDLE.
- fwd_done  in  1  forward-pass-complete pulse from the datapath.
- bwd_done  in  1  delta-computation-complete pulse from the backprop datapath.
- ctrl  out  4  command to the datapath and parameter blocks.
- step  out  4  iteration counter; 0 = no iteration completed, parameter updates inhibited.
- layer_sel  out  NUM_LAYERS  one-hot enable of the layer committing this cycle; all-zero outside UPDATE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an iteration completes.
- err  out  1  watchdog error flag; tied 0 when WATCHDOG_EN is not defined.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: state = IDLE, ctrl = 0000, step = 0000, layer_sel = 0, busy = 0, done = 0, err = 0. rst takes priority over every other input. rst asserted mid-iteration aborts to IDLE on the next edge with no further update pulses.
- ctrl encoding: 0000 IDLE/DONE, 0100 FORWARD, 0010 BACKWARD, 0001 UPDATE. Outputs are registered and change on the edge that enters each state.
- IDLE: on start = 1, go to FORWARD next cycle. start in any other state is ignored; it is not queued.
- FORWARD: wait for fwd_done, then go to BACKWARD. fwd_done and bwd_done arriving together in FORWARD: only fwd_done is honoured. A stray bwd_done is ignored.
- BACKWARD: wait for bwd_done, then go to UPDATE. fwd_done is ignored here.
- Step advance: step increments on the edge entering UPDATE, so the parameter blocks see step != 0 while ctrl = 0001. Wrap is 15 -> 1; step never returns to 0 after the first iteration.
- UPDATE: lasts exactly NUM_LAYERS cycles.
  - ctrl = 0001 on every UPDATE cycle.
  - layer_sel = 1 << k on UPDATE cycle k, k = 0..NUM_LAYERS-1.
  - Each layer commits exactly once per iteration.
  - Then go to DONE.
- DONE: one cycle. ctrl = 0000, done = 1, then IDLE. Earliest restart: start high in the cycle after DONE is accepted in IDLE.
- Minimum iteration latency, with fwd_done and bwd_done each arriving in the first cycle of their state: 1 FORWARD + 1 BACKWARD + NUM_LAYERS UPDATE + 1 DONE cycles after start is accepted.
- busy is high from the FORWARD entry through the DONE cycle inclusive.

Optional Feature:
- Macro: DQN_SEQ_WATCHDOG_EN.
- When defined:
  - An 8+ bit counter clears on entering FORWARD or BACKWARD and counts while waiting there.
  - If the count reaches WD_LIMIT without the expected done pulse, go to IDLE next cycle. No UPDATE occurs and step is unchanged.
  - err is set and remains sticky until rst. A new start is still accepted while err = 1.
- When not defined: no counter, err is constant 0, and FORWARD/BACKWARD wait indefinitely.

Test Plan:
- Reset then idle: rst high for 2 cycles, then 10 idle cycles -> ctrl = 0000, step = 0, layer_sel = 0, busy = 0, done = 0 throughout.
- Nominal iteration: NUM_LAYERS = 2; start; fwd_done after 3 cycles; bwd_done after 5 cycles -> ctrl sequence 0100, 0010, 0001, 0001, 0000. layer_sel = 01 then 10. step 0 -> 1 on UPDATE entry. done pulses once.
- Wrap: run 16 iterations -> step reads 1..15 then 1; step is never 0 during any UPDATE cycle.
- Spurious and simultaneous handshakes:
  - start and bwd_done asserted while in BACKWARD -> start ignored, iteration completes normally, no second iteration.
  - fwd_done + bwd_done together in FORWARD -> enters BACKWARD only.
- Reset mid-update: rst asserted on the first UPDATE cycle -> next cycle ctrl = 0000, layer_sel = 0, step = 0. Exactly one layer_sel pulse was observed.
- Watchdog (DQN_SEQ_WATCHDOG_EN defined, WD_LIMIT = 10): start, withhold fwd_done -> return to IDLE within 11 cycles, err = 1, step unchanged, no ctrl = 0001 observed.

Source files
------------

// File: rtl/dqn_update_sequencer.sv
// Training-iteration sequencer: FORWARD -> BACKWARD -> per-layer UPDATE -> DONE, driving the ctrl/step bus.
// Optional watchdog on the FORWARD/BACKWARD waits is built in when DQN_SEQ_WATCHDOG_EN is defined.
module dqn_update_sequencer #(
    parameter int NUM_LAYERS = 2,
    parameter int WD_LIMIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  fwd_done,
    input  logic                  bwd_done,
    output logic [3:0]            ctrl,
    output logic [3:0]            step,
    output logic [NUM_LAYERS-1:0] layer_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_BWD,
        S_UPD,
        S_DONE
    } state_t;

    localparam int            CW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_LAYERS - 1);

    state_t                  r_state, w_state_next;
    logic [CW-1:0]           r_upd_cnt, w_upd_cnt_next;
    logic [3:0]              r_step, w_step_next;
    logic [3:0]              r_ctrl, w_ctrl_next;
    logic [NUM_LAYERS-1:0]   r_layer_sel, w_layer_sel_next;
    logic                    r_busy, r_done;
    logic                    w_wd_expired;

`ifdef DQN_SEQ_WATCHDOG_EN
    localparam int WDW = (WD_LIMIT > 255) ? $clog2(WD_LIMIT + 1) : 8;

    logic [WDW-1:0] r_wd_cnt;
    logic           r_err;

    // Count value WD_LIMIT-1 marks the WD_LIMIT-th waiting cycle.
    assign w_wd_expired = (r_wd_cnt >= WDW'(WD_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_state_next != r_state)
                r_wd_cnt <= '0;
            else if (r_state == S_FWD || r_state == S_BWD)
                r_wd_cnt <= r_wd_cnt + 1'b1;
            if ((r_state == S_FWD || r_state == S_BWD) && w_state_next == S_IDLE)
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_wd_expired = 1'b0;
    // WD_LIMIT only matters with the watchdog built in; err is constant 0 here.
    assign err = (WD_LIMIT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_upd_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_upd_cnt <= w_upd_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_upd_cnt_next = r_upd_cnt;
        w_step_next    = r_step;
        w_ctrl_next    = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_next = S_FWD;
            end
            S_FWD: begin
                if (fwd_done)
                    w_state_next = S_BWD;
                else if (w_wd_expired)
                    w_state_next = S_IDLE;
            end
            S_BWD: begin
                if (bwd_done) begin
                    w_state_next   = S_UPD;
                    w_upd_cnt_next = '0;
                    // Step skips 0 on wrap so updates are never inhibited after the first iteration.
                    w_step_next    = (r_step == 4'd15) ? 4'd1 : r_step + 4'd1;
                end else if (w_wd_expired) begin
                    w_state_next = S_IDLE;
                end
            end
            S_UPD: begin
                if (r_upd_cnt == LAST)
                    w_state_next = S_DONE;
                else
                    w_upd_cnt_next = r_upd_cnt + 1'b1;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        case (w_state_next)
            S_FWD:   w_ctrl_next = 4'b0100;
            S_BWD:   w_ctrl_next = 4'b0010;
            S_UPD:   w_ctrl_next = 4'b0001;
            default: w_ctrl_next = 4'b0000;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer_sel
            assign w_layer_sel_next[gi] = (w_state_next == S_UPD) && (w_upd_cnt_next == CW'(gi));
        end
    endgenerate

    // Outputs are registered from the next-state decode so they switch on the entering edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl      <= 4'b0000;
            r_step      <= 4'd0;
            r_layer_sel <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_ctrl      <= w_ctrl_next;
            r_step      <= w_step_next;
            r_layer_sel <= w_layer_sel_next;
            r_busy      <= (w_state_next != S_IDLE);
            r_done      <= (w_state_next == S_DONE);
        end
    end

    assign ctrl      = r_ctrl;
    assign step      = r_step;
    assign layer_sel = r_layer_sel;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
